// File: rtl/serdes_pkg.sv
// serdes_pkg: shared symbols, widths and lane states for the serdes blocks
package serdes_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;
  typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} lane_state_t;
endpackage

// File: rtl/serial_paralelo_lane_com_detector.sv
// com_detector: serial shift register with a COM compare on the window including the current bit
module com_detector
  import serdes_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM = COM_SYM
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] win,
  output logic              is_com
);
  logic [BYTE_W-1:0] sr;
  // shift one bit in per clock, MSB of each byte first
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[BYTE_W-2:0], data_in};
  end
  assign win    = {sr[BYTE_W-2:0], data_in};
  assign is_com = win == COM;
endmodule

// File: rtl/serial_paralelo_lane.sv
// serial_paralelo_lane: per-lane deserializer that locks byte boundaries on consecutive COM symbols
module serial_paralelo_lane
  import serdes_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM      = COM_SYM,
  parameter int                BC_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);
  localparam logic [3:0] BC_TGT = 4'(BC_COUNT);
  lane_state_t       state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [3:0]        com_cnt, com_cnt_n;
  logic [BYTE_W-1:0] win, data_out_n;
  logic              is_com, valid_n, active_n, boundary;

  com_detector #(.COM(COM)) u_det (
    .clk_8f (clk_8f),
    .reset  (reset),
    .data_in(data_in),
    .win    (win),
    .is_com (is_com)
  );

  assign boundary = bit_cnt == 3'd7;

  // state, counters and registered outputs
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      com_cnt   <= com_cnt_n;
      data_out  <= data_out_n;
      valid_out <= valid_n;
      active    <= active_n;
    end
  end

  // SEARCH realigns the bit counter on any COM; SYNC/ACTIVE only look at boundary windows
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt + 3'd1;
    com_cnt_n  = com_cnt;
    data_out_n = data_out;
    valid_n    = valid_out;
    active_n   = active;
    case (state)
      SEARCH: if (is_com) begin
        bit_cnt_n = '0;
        com_cnt_n = 4'd1;
        state_n   = SYNC;
      end
      SYNC: if (boundary) begin
        com_cnt_n = is_com ? com_cnt + 4'd1 : '0;
        state_n   = !is_com ? SEARCH : (com_cnt + 4'd1 == BC_TGT) ? ACTIVE : SYNC;
        active_n  = is_com && (com_cnt + 4'd1 == BC_TGT);
      end
      ACTIVE: if (boundary) begin
        data_out_n = is_com ? COM : win;
        valid_n    = !is_com;
      end
      default: state_n = SEARCH;
    endcase
  end
endmodule
